axis_pipe_reg: RTL and testbench
================================

# axis_pipe_reg

Parametrised AXI4-Stream elastic register pipeline: a DEPTH-entry buffer with registered outputs and registered `s_axis_tready`.
- Accepts one beat per cycle.
- Never inserts bubbles.
- Exposes occupancy for upstream pacing.
- Sits on long stream routes between the DMA/packer logic and the engine, where a single skid stage cannot absorb ready round-trip latency.

## Interface
- `DATA_WIDTH`, 8: tdata width in bits.
- `KEEP_ENABLE`, (DATA_WIDTH>8): propagate tkeep; when 0, `m_axis_tkeep` is all ones.
- `KEEP_WIDTH`, DATA_WIDTH/8: tkeep width.
- `LAST_ENABLE`, 1: propagate tlast; when 0, `m_axis_tlast` = 1.
- `ID_ENABLE` / `ID_WIDTH`, 0 / 8: tid propagation and width; when disabled, the output is 0.
- `DEST_ENABLE` / `DEST_WIDTH`, 0 / 8: tdest propagation and width; when disabled, the output is 0.
- `USER_ENABLE` / `USER_WIDTH`, 1 / 1: tuser propagation and width; when disabled, the output is 0.
- `DEPTH`, 4: total beats held, including the output register; power of two, ≥2.
- `LW`, $clog2(DEPTH+1): width of `level`.

Ports:
- `clk` input 1: single clock; all logic is posedge.
- `rstn` input 1: synchronous, active-low reset.
- `rstn_local` input 1: synchronous, active-low flush; clears control state only.
- `s_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser` input: upstream beat, widths per the parameters.
- `s_axis_tready` output 1: registered ready.
- `m_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser` output: registered downstream beat.
- `m_axis_tready` input 1: downstream ready.
- `level` output LW: beats currently held (0..DEPTH).

## Operation
- Storage:
  - One output register plus a circular buffer of DEPTH-1 entries, with read and write pointers of $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH-1 (pointer-based); use explicit compare-and-reset, not bit overflow.
- Per-cycle handshake terms:
  - push = `s_axis_tvalid` & `s_axis_tready`.
  - pop = `m_axis_tvalid` & `m_axis_tready`.
  - count_next = count + push − pop.
- Output register load:
  - From the buffer head when pop (or the output is empty) and the buffer is non-empty.
  - Otherwise directly from the input when push and the buffer is empty (bypass into the output).
  - Otherwise hold.
- Routing of pushed beats: a pushed beat not loaded into the output is written at the write pointer. Beat order is strictly preserved.
- `m_axis_tvalid` is registered: high iff the output register holds a beat.
- `s_axis_tready` is registered: `s_axis_tready` <= (count_next < DEPTH). This gives full throughput at any occupancy below DEPTH, including simultaneous push and pop at count=DEPTH−1.
- Simultaneous push and pop at count=DEPTH is impossible, because ready is low.
- While `m_axis_tvalid` is high and `m_axis_tready` is low, all m_axis payload outputs remain stable.
- Disabled sideband fields are not stored; their outputs are the constants listed above.

## Timing
- Reset (`rstn`=0 at a clock edge) values:
  - `s_axis_tready`=0, `m_axis_tvalid`=0, count=0, pointers=0.
  - All m_axis payload registers = 0, so every output is 0 except the constant-driven disabled fields.
- Ready after reset: first cycle after release, `s_axis_tready`=0; it is 1 from the second edge after release.
- Flush (`rstn_local`=0 with `rstn`=1):
  - Same control clear as reset; payload registers keep their values.
  - Beats in flight are discarded.
  - Flush mid-packet is permitted; no tlast is synthesised.
- Latency:
  - A beat pushed into an empty block appears on m_axis at the next cycle (1-cycle latency).
  - With the buffer non-empty, beats emerge in FIFO order; m_axis throughput is 1 beat/cycle while `m_axis_tready`=1.
- Boundary: `level` is registered and equals count.

## Configuration
- `AXIS_PIPE_LEVEL_EN`:
  - Defined: the `level` port is driven by the registered count.
  - Undefined: `level` is tied to 0 and the count comparison is the only count logic.
- Ready generation is identical in both builds.

## Test plan
- Reset, then a continuous burst:
  - Stimulus: release `rstn`; `s_axis_tvalid`=1 with data 0x01,0x02,…,0x10; `m_axis_tready`=1.
  - Response: `s_axis_tready` is high from the second edge; output 0x01..0x10 in order, one per cycle, 1-cycle latency, no bubbles.
- Fill to full:
  - Stimulus: DEPTH=4, `m_axis_tready`=0, push 6 beats.
  - Response: exactly 4 accepted; `s_axis_tready`=0 from the edge after the 4th push; `level`=4; the m_axis beat is stable at the first datum.
- Full-throughput turnaround:
  - Stimulus: at `level`=3, push and pop in the same cycle.
  - Response: `level` stays 3, `s_axis_tready` stays 1, and no beat is lost or duplicated.
- Drain with wrap:
  - Stimulus: 1000 beats of random valid/ready with DEPTH=4.
  - Response: the output sequence equals the input sequence, including tlast and tuser per beat; pointer wrap is exercised.
- Flush mid-packet:
  - Stimulus: 3 beats held; pulse `rstn_local` for 1 cycle.
  - Response: `m_axis_tvalid`=0, `level`=0, `s_axis_tready` returns to 1 two edges later, and a new beat passes unmodified.
- Sideband disable:
  - Stimulus: `LAST_ENABLE`=0, `KEEP_ENABLE`=0, DATA_WIDTH=32.
  - Response: `m_axis_tlast`=1 and `m_axis_tkeep`=0xF on every beat.

Source files
------------

// File: rtl/axis_pipe_reg.sv
// axis_pipe_reg: AXI4-Stream elastic register pipeline.
// Holds up to DEPTH beats: one output register plus a circular buffer of
// DEPTH-1 entries. The m_axis outputs and s_axis_tready are all registered,
// so neither the forward path nor the ready path adds combinational depth.
// Build option: define AXIS_PIPE_LEVEL_EN to drive `level` from the beat
// count; without it `level` is tied to zero.
module axis_pipe_reg #(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit LAST_ENABLE = 1'b1,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 4,
  parameter int LW          = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rstn_local,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [LW-1:0]         level
);

  localparam int BD       = DEPTH - 1;
  localparam int PW       = $clog2(DEPTH);
  localparam int KW_E     = KEEP_ENABLE ? KEEP_WIDTH : 0;
  localparam int LA_E     = LAST_ENABLE ? 1 : 0;
  localparam int ID_E     = ID_ENABLE ? ID_WIDTH : 0;
  localparam int DE_E     = DEST_ENABLE ? DEST_WIDTH : 0;
  localparam int US_E     = USER_ENABLE ? USER_WIDTH : 0;
  localparam int KEEP_OFF = DATA_WIDTH;
  localparam int LAST_OFF = KEEP_OFF + KW_E;
  localparam int ID_OFF   = LAST_OFF + LA_E;
  localparam int DEST_OFF = ID_OFF + ID_E;
  localparam int USER_OFF = DEST_OFF + DE_E;
  localparam int PL_W     = USER_OFF + US_E;

  // Only enabled sideband fields are packed into the stored payload word.
  logic [PL_W-1:0] in_pl;
  logic [PL_W-1:0] out_pl;
  logic [PL_W-1:0] mem [BD];

  logic [LW-1:0] count;
  logic [LW-1:0] count_next;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          out_valid;
  logic          out_valid_next;
  logic          ready;
  logic          ready_en;
  logic          push;
  logic          pop;
  logic          buf_empty;
  logic          out_free;
  logic          load_buf;
  logic          load_in;
  logic          write_buf;

  assign in_pl[DATA_WIDTH-1:0] = s_axis_tdata;
  assign m_axis_tdata          = out_pl[DATA_WIDTH-1:0];

  if (KEEP_ENABLE) begin : g_keep
    assign in_pl[KEEP_OFF +: KEEP_WIDTH] = s_axis_tkeep;
    assign m_axis_tkeep = out_pl[KEEP_OFF +: KEEP_WIDTH];
  end else begin : g_no_keep
    logic unused_keep;
    assign unused_keep  = ^s_axis_tkeep;
    assign m_axis_tkeep = '1;
  end

  if (LAST_ENABLE) begin : g_last
    assign in_pl[LAST_OFF] = s_axis_tlast;
    assign m_axis_tlast    = out_pl[LAST_OFF];
  end else begin : g_no_last
    logic unused_last;
    assign unused_last  = s_axis_tlast;
    assign m_axis_tlast = 1'b1;
  end

  if (ID_ENABLE) begin : g_id
    assign in_pl[ID_OFF +: ID_WIDTH] = s_axis_tid;
    assign m_axis_tid = out_pl[ID_OFF +: ID_WIDTH];
  end else begin : g_no_id
    logic unused_id;
    assign unused_id  = ^s_axis_tid;
    assign m_axis_tid = '0;
  end

  if (DEST_ENABLE) begin : g_dest
    assign in_pl[DEST_OFF +: DEST_WIDTH] = s_axis_tdest;
    assign m_axis_tdest = out_pl[DEST_OFF +: DEST_WIDTH];
  end else begin : g_no_dest
    logic unused_dest;
    assign unused_dest  = ^s_axis_tdest;
    assign m_axis_tdest = '0;
  end

  if (USER_ENABLE) begin : g_user
    assign in_pl[USER_OFF +: USER_WIDTH] = s_axis_tuser;
    assign m_axis_tuser = out_pl[USER_OFF +: USER_WIDTH];
  end else begin : g_no_user
    logic unused_user;
    assign unused_user  = ^s_axis_tuser;
    assign m_axis_tuser = '0;
  end

  assign s_axis_tready = ready;
  assign m_axis_tvalid = out_valid;

  // Buffer pointers wrap at DEPTH-1 entries, which is not a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BD - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake terms and the per-cycle routing decision (buffer head first, then bypass).
  always_comb begin
    push           = s_axis_tvalid && ready;
    pop            = out_valid && m_axis_tready;
    buf_empty      = (count == LW'(out_valid));
    out_free       = pop || !out_valid;
    load_buf       = out_free && !buf_empty;
    load_in        = out_free && buf_empty && push;
    write_buf      = push && !load_in;
    out_valid_next = out_valid;
    if (load_buf || load_in) begin
      out_valid_next = 1'b1;
    end else if (pop) begin
      out_valid_next = 1'b0;
    end
    count_next = count + LW'(push) - LW'(pop);
  end

  // Control state; ready_en holds ready low for one extra cycle after reset or flush.
  always_ff @(posedge clk) begin
    if (!rstn || !rstn_local) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      ready     <= 1'b0;
      ready_en  <= 1'b0;
    end else begin
      count     <= count_next;
      out_valid <= out_valid_next;
      ready_en  <= 1'b1;
      ready     <= ready_en && (count_next < LW'(DEPTH));
      if (write_buf) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (load_buf) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Buffer storage write; payload memory needs no reset.
  always_ff @(posedge clk) begin
    if (rstn && rstn_local && write_buf) begin
      mem[wr_ptr] <= in_pl;
    end
  end

  // Output payload register; a flush leaves the last payload in place.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_pl <= '0;
    end else if (rstn_local) begin
      if (load_buf) begin
        out_pl <= mem[rd_ptr];
      end else if (load_in) begin
        out_pl <= in_pl;
      end
    end
  end

`ifdef AXIS_PIPE_LEVEL_EN
  assign level = count;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_axis_pipe_reg.sv
// tb_axis_pipe_reg: self-checking bench for axis_pipe_reg. Instance dut uses
// the default 8-bit configuration; instance dut_b is 32 bits wide with tkeep
// and tlast disabled. Expected behaviour comes from a queue-based model of
// the stream contents.
module tb_axis_pipe_reg;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef AXIS_PIPE_LEVEL_EN
  localparam bit LEVEL_EN = 1'b1;
`else
  localparam bit LEVEL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic clk = 1'b0;
  logic rstn;
  logic rstn_local;

  logic [7:0]    s_tdata;
  logic [0:0]    s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [7:0]    s_tid;
  logic [7:0]    s_tdest;
  logic [0:0]    s_tuser;
  logic [7:0]    m_tdata;
  logic [0:0]    m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [7:0]    m_tid;
  logic [7:0]    m_tdest;
  logic [0:0]    m_tuser;
  logic [LW-1:0] level;

  logic [31:0]   b_s_tdata;
  logic [3:0]    b_s_tkeep;
  logic          b_s_tvalid;
  logic          b_s_tready;
  logic          b_s_tlast;
  logic [7:0]    b_s_tid;
  logic [7:0]    b_s_tdest;
  logic [0:0]    b_s_tuser;
  logic [31:0]   b_m_tdata;
  logic [3:0]    b_m_tkeep;
  logic          b_m_tvalid;
  logic          b_m_tready;
  logic          b_m_tlast;
  logic [7:0]    b_m_tid;
  logic [7:0]    b_m_tdest;
  logic [0:0]    b_m_tuser;
  logic [LW-1:0] b_level;

  beat_t       q[$];
  logic [31:0] bq[$];
  int          since_clear = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  axis_pipe_reg #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .rstn_local(rstn_local),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .level(level)
  );

  axis_pipe_reg #(
    .DATA_WIDTH(32), .KEEP_ENABLE(1'b0), .LAST_ENABLE(1'b0), .DEPTH(DEPTH)
  ) dut_b (
    .clk(clk), .rstn(rstn), .rstn_local(rstn_local),
    .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
    .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast), .s_axis_tid(b_s_tid),
    .s_axis_tdest(b_s_tdest), .s_axis_tuser(b_s_tuser),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
    .m_axis_tready(b_m_tready), .m_axis_tlast(b_m_tlast), .m_axis_tid(b_m_tid),
    .m_axis_tdest(b_m_tdest), .m_axis_tuser(b_m_tuser),
    .level(b_level)
  );

  // Ready is expected two edges after a clear, whenever fewer than DEPTH beats are held.
  function automatic bit exp_ready_a();
    return (since_clear >= 2) && (q.size() < DEPTH);
  endfunction

  function automatic bit exp_ready_b();
    return (since_clear >= 2) && (bq.size() < DEPTH);
  endfunction

  function automatic logic [LW-1:0] exp_level();
    return LEVEL_EN ? LW'(q.size()) : '0;
  endfunction

  // One clock: record handshakes seen before the edge, then update the model.
  task automatic tick();
    bit    clear, push_a, pop_a, push_b, pop_b;
    beat_t nb;
    logic [31:0] nbd;
    clear  = !rstn || !rstn_local;
    push_a = s_tvalid && s_tready;
    pop_a  = (q.size() > 0) && m_tready;
    push_b = b_s_tvalid && b_s_tready;
    pop_b  = (bq.size() > 0) && b_m_tready;
    nb     = '{data: s_tdata, last: s_tlast, user: s_tuser[0]};
    nbd    = b_s_tdata;
    @(posedge clk);
    #1;
    if (clear) begin
      q.delete();
      bq.delete();
      since_clear = 0;
    end else begin
      if (pop_a) void'(q.pop_front());
      if (push_a) q.push_back(nb);
      if (pop_b) void'(bq.pop_front());
      if (push_b) bq.push_back(nbd);
      if (since_clear < 2) since_clear++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({s_tready, m_tvalid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got ready/valid %b%b want 00", s_tready, m_tvalid);
    end
    checks++;
    if ({m_tdata, m_tlast, m_tuser, m_tid, m_tdest} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_payload: got %h %b %b %h %h want zeros", m_tdata, m_tlast, m_tuser, m_tid, m_tdest);
    end
    checks++;
    if (m_tkeep !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_keep: got %b want 1", m_tkeep);
    end
    checks++;
    if (level !== '0) begin
      errors++;
      $display("[TB] FAIL reset_level: got %0d want 0", level);
    end
    checks++;
    if ({b_m_tlast, b_m_tkeep} !== 5'b1_1111) begin
      errors++;
      $display("[TB] FAIL reset_b_const: got last %b keep %h want 1 f", b_m_tlast, b_m_tkeep);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_first_edge: got %b want 0", s_tready);
    end
    tick();
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_second_edge: got %b want 1", s_tready);
    end
  endtask

  task automatic test_burst();
    int next_in = 1;
    m_tready = 1'b1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      checks++;
      if (m_tvalid !== (cyc >= 1 && cyc <= 16)) begin
        errors++;
        $display("[TB] FAIL burst_valid cyc %0d: got %b want %b", cyc, m_tvalid, (cyc >= 1 && cyc <= 16));
      end
      if (cyc >= 1 && cyc <= 16) begin
        checks++;
        if (m_tdata !== 8'(cyc)) begin
          errors++;
          $display("[TB] FAIL burst_data cyc %0d: got %h want %h", cyc, m_tdata, 8'(cyc));
        end
      end
      checks++;
      if (s_tready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL burst_ready cyc %0d: got %b want 1", cyc, s_tready);
      end
      s_tvalid = (next_in <= 16);
      s_tdata  = 8'(next_in);
      s_tlast  = (next_in == 16);
      s_tuser  = 1'b0;
      if (s_tvalid && s_tready) next_in++;
      tick();
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_fill();
    int accepted = 0;
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (s_tready !== exp_ready_a()) begin
        errors++;
        $display("[TB] FAIL fill_ready step %0d: got %b want %b", i, s_tready, exp_ready_a());
      end
      if (accepted > 0) begin
        checks++;
        if ({m_tvalid, m_tdata} !== {1'b1, 8'hA0}) begin
          errors++;
          $display("[TB] FAIL fill_stable step %0d: got %b/%h want 1/a0", i, m_tvalid, m_tdata);
        end
      end
      s_tvalid = 1'b1;
      s_tdata  = 8'hA0 + 8'(accepted);
      s_tlast  = 1'b0;
      s_tuser  = 1'b1;
      if (s_tready) accepted++;
      tick();
    end
    s_tvalid = 1'b0;
    checks++;
    if (accepted != 4) begin
      errors++;
      $display("[TB] FAIL fill_accepted: got %0d want 4", accepted);
    end
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_full_ready: got %b want 0", s_tready);
    end
    checks++;
    if (level !== (LEVEL_EN ? LW'(4) : LW'(0))) begin
      errors++;
      $display("[TB] FAIL fill_level: got %0d want %0d", level, (LEVEL_EN ? 4 : 0));
    end
    checks++;
    if ({m_tvalid, m_tdata} !== {1'b1, 8'hA0}) begin
      errors++;
      $display("[TB] FAIL fill_head: got %b/%h want 1/a0", m_tvalid, m_tdata);
    end
  endtask

  task automatic test_turnaround();
    int guard = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({s_tready, level} !== {1'b1, (LEVEL_EN ? LW'(3) : LW'(0))}) begin
        errors++;
        $display("[TB] FAIL turn_ready_level step %0d: got %b/%0d want 1/%0d", i, s_tready, level, (LEVEL_EN ? 3 : 0));
      end
      checks++;
      if (q.size() == 0 || {m_tvalid, m_tdata} !== {1'b1, q[0].data}) begin
        errors++;
        $display("[TB] FAIL turn_data step %0d: got %b/%h want 1/%h", i, m_tvalid, m_tdata, (q.size() > 0) ? q[0].data : 8'h00);
      end
      s_tvalid = 1'b1;
      s_tdata  = 8'hC0 + 8'(i);
      tick();
    end
    s_tvalid = 1'b0;
    while (q.size() > 0 && guard < 10) begin
      checks++;
      if ({m_tvalid, m_tdata} !== {1'b1, q[0].data}) begin
        errors++;
        $display("[TB] FAIL turn_drain: got %b/%h want 1/%h", m_tvalid, m_tdata, q[0].data);
      end
      tick();
      guard++;
    end
    checks++;
    if (m_tvalid !== 1'b0 || guard >= 10) begin
      errors++;
      $display("[TB] FAIL turn_empty: got valid %b after %0d cycles want 0", m_tvalid, guard);
    end
  endtask

  task automatic test_random_drain();
    int sent = 0;
    int cyc  = 0;
    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      checks++;
      if (m_tvalid !== (q.size() > 0)) begin
        errors++;
        $display("[TB] FAIL rand_valid cyc %0d: got %b want %b", cyc, m_tvalid, (q.size() > 0));
      end
      if (q.size() > 0) begin
        checks++;
        if ({m_tdata, m_tlast, m_tuser} !== {q[0].data, q[0].last, q[0].user}) begin
          errors++;
          $display("[TB] FAIL rand_beat cyc %0d: got %h/%b/%b want %h/%b/%b", cyc, m_tdata, m_tlast, m_tuser, q[0].data, q[0].last, q[0].user);
        end
      end
      checks++;
      if (s_tready !== exp_ready_a()) begin
        errors++;
        $display("[TB] FAIL rand_ready cyc %0d: got %b want %b", cyc, s_tready, exp_ready_a());
      end
      checks++;
      if (level !== exp_level()) begin
        errors++;
        $display("[TB] FAIL rand_level cyc %0d: got %0d want %0d", cyc, level, exp_level());
      end
      s_tvalid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      s_tdata  = 8'($urandom);
      s_tlast  = 1'($urandom);
      s_tuser  = 1'($urandom);
      m_tready = ($urandom_range(0, 2) != 0);
      if (s_tvalid && s_tready) sent++;
      tick();
      cyc++;
    end
    s_tvalid = 1'b0;
    checks++;
    if (cyc >= 20000) begin
      errors++;
      $display("[TB] FAIL rand_timeout: sent %0d held %0d", sent, q.size());
    end
  endtask

  task automatic test_flush();
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'h31 + 8'(i);
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
      tick();
    end
    s_tvalid = 1'b0;
    checks++;
    if ({m_tvalid, m_tdata, level} !== {1'b1, 8'h31, (LEVEL_EN ? LW'(3) : LW'(0))}) begin
      errors++;
      $display("[TB] FAIL flush_pre: got %b/%h/%0d want 1/31/%0d", m_tvalid, m_tdata, level, (LEVEL_EN ? 3 : 0));
    end
    rstn_local = 1'b0;
    tick();
    rstn_local = 1'b1;
    checks++;
    if ({m_tvalid, s_tready, level} !== {2'b00, LW'(0)}) begin
      errors++;
      $display("[TB] FAIL flush_ctrl: got valid %b ready %b level %0d want 0 0 0", m_tvalid, s_tready, level);
    end
    checks++;
    if (m_tdata !== 8'h31) begin
      errors++;
      $display("[TB] FAIL flush_payload_kept: got %h want 31", m_tdata);
    end
    tick();
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_ready_1: got %b want 0", s_tready);
    end
    tick();
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_ready_2: got %b want 1", s_tready);
    end
    s_tvalid = 1'b1;
    s_tdata  = 8'h5A;
    s_tlast  = 1'b1;
    s_tuser  = 1'b1;
    m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tuser} !== {1'b1, 8'h5A, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL flush_new_beat: got %b/%h/%b/%b want 1/5a/1/1", m_tvalid, m_tdata, m_tlast, m_tuser);
    end
    tick();
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_after: got valid %b want 0", m_tvalid);
    end
  endtask

  task automatic test_sideband();
    b_m_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (b_m_tvalid !== (bq.size() > 0)) begin
        errors++;
        $display("[TB] FAIL side_valid step %0d: got %b want %b", i, b_m_tvalid, (bq.size() > 0));
      end
      checks++;
      if (b_s_tready !== exp_ready_b()) begin
        errors++;
        $display("[TB] FAIL side_ready step %0d: got %b want %b", i, b_s_tready, exp_ready_b());
      end
      if (bq.size() > 0) begin
        checks++;
        if ({b_m_tdata, b_m_tlast, b_m_tkeep} !== {bq[0], 1'b1, 4'hF}) begin
          errors++;
          $display("[TB] FAIL side_beat step %0d: got %h/%b/%h want %h/1/f", i, b_m_tdata, b_m_tlast, b_m_tkeep, bq[0]);
        end
      end
      b_s_tvalid = (i < 6);
      b_s_tdata  = $urandom;
      b_s_tkeep  = 4'h0;
      b_s_tlast  = 1'b0;
      b_s_tuser  = 1'($urandom);
      tick();
    end
    b_s_tvalid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn       = 1'b0;
    rstn_local = 1'b1;
    s_tdata    = '0;
    s_tkeep    = 1'b1;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    s_tid      = '0;
    s_tdest    = '0;
    s_tuser    = '0;
    m_tready   = 1'b0;
    b_s_tdata  = '0;
    b_s_tkeep  = '0;
    b_s_tvalid = 1'b0;
    b_s_tlast  = 1'b0;
    b_s_tid    = '0;
    b_s_tdest  = '0;
    b_s_tuser  = '0;
    b_m_tready = 1'b0;
    test_reset();
    test_burst();
    test_fill();
    test_turnaround();
    test_random_drain();
    test_flush();
    test_sideband();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
